// File: rtl/brightness_ctrl_if.sv
// Brightness control bus: the four raw push-buttons going into the block and
// the registered brightness/mode state coming back out.
//   btn_up, btn_dn   : raw level step buttons, high = pressed
//   btn_mode         : raw button toggling breathing mode
//   btn_en           : raw button toggling the PWM enable
//   level[5:0]       : duty reference for the PWM/breathing stage
//   breathe          : 1 = sine breathing, 0 = fixed duty
//   enable           : PWM enable
//   level_changed    : one-cycle pulse whenever level takes a new value
// master = whoever owns the buttons (board pins / testbench),
// slave  = the brightness controller itself.
interface brightness_ctrl_if;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_mode;
  logic       btn_en;
  logic [5:0] level;
  logic       breathe;
  logic       enable;
  logic       level_changed;

  modport master (
    output btn_up, btn_dn, btn_mode, btn_en,
    input  level, breathe, enable, level_changed
  );

  modport slave (
    input  btn_up, btn_dn, btn_mode, btn_en,
    output level, breathe, enable, level_changed
  );
endinterface

// File: rtl/brightness_ctrl.sv
// Brightness controller: turns four raw push-buttons into a 6-bit brightness
// level with press-and-hold auto-repeat, plus breathe/enable toggles.
// Ports:
//   clk  : single clock, everything changes on its rising edge
//   rst  : synchronous active-high reset
//   bus  : brightness_ctrl_if.slave (raw buttons in, registered state out)
// Each button goes through a two-flop synchronizer, then its own debouncer,
// then a registered rising-edge detector producing a one-cycle press event.
// Up/down presses drive a small IDLE/DELAY/REPEAT state machine that steps
// the level once on press, again after REPEAT_DELAY cycles of holding, and
// then every REPEAT_PERIOD cycles until the button is released.
module brightness_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  brightness_ctrl_if.slave  bus
);

  // Button positions inside the packed button vectors.
  localparam int BTN_UP   = 0;
  localparam int BTN_DN   = 1;
  localparam int BTN_MODE = 2;
  localparam int BTN_EN   = 3;

  // The debounce counter only ever holds 0..DEBOUNCE_CYCLES-1 because it
  // clears on the cycle it would reach DEBOUNCE_CYCLES.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // One timer serves both the initial delay and the repeat period.
  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  localparam logic [5:0] LEVEL_RESET = 6'd32;
  localparam logic [5:0] LEVEL_MAX   = 6'd63;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_e;

  logic [3:0]       raw_btn;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [CNT_W-1:0] db_cnt_q [4];
  logic [CNT_W-1:0] db_cnt_d [4];
  logic [3:0]       db_q, db_d;
  logic [3:0]       db_prev_q, db_prev_d;
  logic [3:0]       press_q, press_d;
  state_e           state_q, state_d;
  logic             dir_up_q, dir_up_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [5:0]       level_q, level_d;
  logic             breathe_q, breathe_d;
  logic             enable_q, enable_d;
  logic             level_changed_q, level_changed_d;

  logic             step;
  logic             step_up;
  logic             hold_ok;

  assign raw_btn = {bus.btn_en, bus.btn_mode, bus.btn_dn, bus.btn_up};

  // Synchronizer, debouncers and press-edge detection for all four buttons.
  // A debouncer only counts while its synchronized input disagrees with the
  // debounced state, so any single agreeing sample restarts the count.
  always_comb begin
    sync1_d   = raw_btn;
    sync2_d   = sync1_q;
    db_d      = db_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    db_prev_d = db_q;
    press_d   = db_q & ~db_prev_q;
  end

  // Up/down auto-repeat state machine and the saturating level update.
  // While holding, leaving the button or pressing the opposite one aborts
  // the hold without a step.
  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    timer_d  = timer_q;
    step     = 1'b0;
    step_up  = dir_up_q;
    hold_ok  = dir_up_q ? (db_q[BTN_UP] && !db_q[BTN_DN])
                        : (db_q[BTN_DN] && !db_q[BTN_UP]);
    case (state_q)
      IDLE: begin
        if (press_q[BTN_UP] && !press_q[BTN_DN]) begin
          step     = 1'b1;
          step_up  = 1'b1;
          dir_up_d = 1'b1;
          timer_d  = '0;
          state_d  = DELAY;
        end else if (press_q[BTN_DN] && !press_q[BTN_UP]) begin
          step     = 1'b1;
          step_up  = 1'b0;
          dir_up_d = 1'b0;
          timer_d  = '0;
          state_d  = DELAY;
        end
      end
      DELAY: begin
        if (!hold_ok) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (timer_q == DELAY_LAST) begin
          step    = 1'b1;
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!hold_ok) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (timer_q == PERIOD_LAST) begin
          step    = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    level_d = level_q;
    if (step) begin
      if (step_up && (level_q != LEVEL_MAX)) begin
        level_d = level_q + 6'd1;
      end else if (!step_up && (level_q != 6'd0)) begin
        level_d = level_q - 6'd1;
      end
    end
    // Saturated steps leave the level untouched and so raise no pulse.
    level_changed_d = (level_d != level_q);

    breathe_d = breathe_q ^ press_q[BTN_MODE];
    enable_d  = enable_q  ^ press_q[BTN_EN];
  end

  // All state registers; reset clears the input pipeline so a button held
  // through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
      db_q            <= '0;
      db_prev_q       <= '0;
      press_q         <= '0;
      state_q         <= IDLE;
      dir_up_q        <= 1'b0;
      timer_q         <= '0;
      level_q         <= LEVEL_RESET;
      breathe_q       <= 1'b0;
      enable_q        <= 1'b1;
      level_changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      db_q            <= db_d;
      db_prev_q       <= db_prev_d;
      press_q         <= press_d;
      state_q         <= state_d;
      dir_up_q        <= dir_up_d;
      timer_q         <= timer_d;
      level_q         <= level_d;
      breathe_q       <= breathe_d;
      enable_q        <= enable_d;
      level_changed_q <= level_changed_d;
    end
  end

  assign bus.level         = level_q;
  assign bus.breathe       = breathe_q;
  assign bus.enable        = enable_q;
  assign bus.level_changed = level_changed_q;

endmodule
